// File: rtl/red_seq.sv
// red_seq: multi-cycle byte-reduction (RED) sequencer built around a shared
// 4-bit carry-lookahead adder slice.
//   sum = sign_extend8(((a[7:0]+b[7:0]) + (a[15:8]+b[15:8])) mod 256)
// Build option: RED_DUAL_SLICE_EN adds a second slice so the low and high
// byte adds run side by side (4 steps instead of 6). Results are identical.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; ready=1
//   STEP   | one nibble add per slice per cycle, step counter selects op
//   DONE   | done pulse, sum valid; ready=1, a new start goes straight to STEP

module red_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef RED_DUAL_SLICE_EN
    localparam logic [2:0] LAST_STEP = 3'd3;
`else
    localparam logic [2:0] LAST_STEP = 3'd5;
`endif

    state_t      state;
    logic [2:0]  step;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  r;
    logic        c;

    // 4-bit carry-lookahead add: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;
        g     = x & y;
        p     = x ^ y;
        cc[0] = cin;
        cc[1] = g[0] | (p[0] & cin);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
        return {cc[4], p ^ cc[3:0]};
    endfunction

    logic [3:0] x0;
    logic [3:0] y0;
    logic       ci0;
    logic [4:0] res0;

`ifdef RED_DUAL_SLICE_EN
    logic       c_hi;
    logic [3:0] x1;
    logic [3:0] y1;
    logic       ci1;
    logic [4:0] res1;

    // Operand select for both slices: slice 0 walks the low byte then the
    // final reduction, slice 1 handles the high byte in steps 0 and 1.
    always_comb begin
        x0  = 4'd0;
        y0  = 4'd0;
        ci0 = 1'b0;
        x1  = 4'd0;
        y1  = 4'd0;
        ci1 = 1'b0;
        case (step)
            3'd0: begin
                x0 = a_q[3:0];   y0 = b_q[3:0];
                x1 = a_q[11:8];  y1 = b_q[11:8];
            end
            3'd1: begin
                x0 = a_q[7:4];   y0 = b_q[7:4];   ci0 = c;
                x1 = a_q[15:12]; y1 = b_q[15:12]; ci1 = c_hi;
            end
            3'd2: begin
                x0 = lo[3:0];    y0 = hi[3:0];
            end
            3'd3: begin
                x0 = lo[7:4];    y0 = hi[7:4];    ci0 = c;
            end
            default: ;
        endcase
        res0 = cla4(x0, y0, ci0);
        res1 = cla4(x1, y1, ci1);
    end
`else
    // Operand select for the single shared slice, one nibble add per step.
    always_comb begin
        x0  = 4'd0;
        y0  = 4'd0;
        ci0 = 1'b0;
        case (step)
            3'd0: begin x0 = a_q[3:0];   y0 = b_q[3:0];              end
            3'd1: begin x0 = a_q[7:4];   y0 = b_q[7:4];   ci0 = c;   end
            3'd2: begin x0 = a_q[11:8];  y0 = b_q[11:8];             end
            3'd3: begin x0 = a_q[15:12]; y0 = b_q[15:12]; ci0 = c;   end
            3'd4: begin x0 = lo[3:0];    y0 = hi[3:0];               end
            3'd5: begin x0 = lo[7:4];    y0 = hi[7:4];    ci0 = c;   end
            default: ;
        endcase
        res0 = cla4(x0, y0, ci0);
    end
`endif

    assign ready = (state != S_STEP);
    assign busy  = (state == S_STEP);

    // Sequencer FSM plus datapath registers; done is a registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= 3'd0;
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            lo    <= 8'd0;
            hi    <= 8'd0;
            r     <= 8'd0;
            c     <= 1'b0;
`ifdef RED_DUAL_SLICE_EN
            c_hi  <= 1'b0;
`endif
            sum   <= 16'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        step  <= 3'd0;
                        state <= S_STEP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (abort) begin
                        step  <= 3'd0;
                        state <= S_IDLE;
                    end else begin
`ifdef RED_DUAL_SLICE_EN
                        case (step)
                            3'd0: begin
                                lo[3:0] <= res0[3:0]; c    <= res0[4];
                                hi[3:0] <= res1[3:0]; c_hi <= res1[4];
                            end
                            3'd1: begin
                                lo[7:4] <= res0[3:0];
                                hi[7:4] <= res1[3:0];
                            end
                            3'd2: begin
                                r[3:0] <= res0[3:0]; c <= res0[4];
                            end
                            3'd3: begin
                                r[7:4] <= res0[3:0];
                                sum    <= {{8{res0[3]}}, res0[3:0], r[3:0]};
                            end
                            default: ;
                        endcase
`else
                        case (step)
                            3'd0: begin lo[3:0] <= res0[3:0]; c <= res0[4]; end
                            3'd1: lo[7:4] <= res0[3:0];
                            3'd2: begin hi[3:0] <= res0[3:0]; c <= res0[4]; end
                            3'd3: hi[7:4] <= res0[3:0];
                            3'd4: begin r[3:0] <= res0[3:0]; c <= res0[4]; end
                            3'd5: begin
                                r[7:4] <= res0[3:0];
                                sum    <= {{8{res0[3]}}, res0[3:0], r[3:0]};
                            end
                            default: ;
                        endcase
`endif
                        if (step == LAST_STEP) begin
                            step  <= 3'd0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end
                default: begin
                    step  <= 3'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq.sv
// Self-checking bench for red_seq: expected sums are pushed at accept and
// popped when the DUT pulses done.
module tb_red_seq;

`ifdef RED_DUAL_SLICE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 7;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    logic [15:0] exp_q[$];

    red_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] red_model(input logic [15:0] x, input logic [15:0] y);
        logic [7:0] lo_b;
        logic [7:0] hi_b;
        logic [7:0] rr;
        lo_b = x[7:0] + y[7:0];
        hi_b = x[15:8] + y[15:8];
        rr   = lo_b + hi_b;
        return {{8{rr[7]}}, rr};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0)
                check("unexpected_done", 1, 0);
            else
                check("sum", sum, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v);
        int lat;
        @(negedge clk);
        check("ready_before_start", ready, 1);
        a = ta;
        b = tb_v;
        start = 1'b1;
        exp_q.push_back(red_model(ta, tb_v));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("busy_after_accept", busy, 1);
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
        check("ready_in_done", ready, 1);
        check("busy_in_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vec_a[5];
        logic [15:0] vec_b[5];
        int n0;
        int t;
        int c1;
        int c2;

        rst = 1'b1; start = 1'b0; abort = 1'b0; a = 16'd0; b = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 16'h0000);
        rst = 1'b0;

        vec_a = '{16'h1234, 16'h0040, 16'hFFFF, 16'h8080, 16'h000F};
        vec_b = '{16'h5678, 16'h0040, 16'hFFFF, 16'h8080, 16'h0001};
        for (int i = 0; i < 5; i++) run_op(vec_a[i], vec_b[i]);
        check("last_sum_0x000f", sum, 16'h0010);

        // start while busy is ignored
        n0 = done_cnt;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        exp_q.push_back(red_model(16'h1234, 16'h5678));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_while_ignored", busy, 1);
        repeat (12) @(negedge clk);
        check("ignore_done_count", done_cnt - n0, 1);
        check("ignore_sum", sum, 16'h0014);

        // abort mid-operation
        run_op(16'h1234, 16'h5678);
        n0 = done_cnt;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - n0, 0);
        check("abort_sum_kept", sum, 16'h0014);

        // reset mid-operation
        run_op(16'h1234, 16'h5678);
        n0 = done_cnt;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", ready, 1);
        check("rst_mid_sum", sum, 16'h0000);
        repeat (10) @(negedge clk);
        check("rst_mid_no_done", done_cnt - n0, 0);

        // back-to-back with start held; abort during DONE must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        exp_q.push_back(red_model(16'h1234, 16'h5678));
        exp_q.push_back(red_model(16'hFFFF, 16'hFFFF));
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF;
        t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_done", done, 1);
        c1 = cyc;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("b2b_reaccept_busy", busy, 1);
        t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        c2 = cyc;
        start = 1'b0;
        check("b2b_second_done", done, 1);
        check("b2b_spacing", c2 - c1, LAT);
        repeat (LAT + 4) @(negedge clk);
        check("b2b_idle", ready, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
